// File: rtl/gpu_fill_engine.sv
// gpu_fill_engine: takes one draw command (pixel, rectangle fill or clear),
// clamps and orders its corners, then streams one framebuffer write per
// clock in raster order (x inner, y outer, both ascending).
module gpu_fill_engine #(
    parameter logic [7:0] FB_MAX_X = 8'd199,
    parameter logic [7:0] FB_MAX_Y = 8'd149
) (
    input  logic       PIXEL_CLOCK,
    input  logic       RESET,
    input  logic [1:0] CMD_OP,
    input  logic [7:0] CMD_X0,
    input  logic [7:0] CMD_Y0,
    input  logic [7:0] CMD_X1,
    input  logic [7:0] CMD_Y1,
    input  logic [2:0] CMD_COLOR,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       ABORT,
    output logic [7:0] FB_X,
    output logic [7:0] FB_Y,
    output logic [2:0] FB_COLOR,
    output logic       FB_WRITE,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL
    } state_t;

    localparam logic [1:0] OP_PIXEL = 2'b00;
    localparam logic [1:0] OP_RECT  = 2'b01;
    localparam logic [1:0] OP_NOP   = 2'b11;

    state_t     state;
    state_t     state_next;

    logic [1:0] op_q;
    logic [7:0] x0_q;
    logic [7:0] y0_q;
    logic [7:0] x1_q;
    logic [7:0] y1_q;
    logic [2:0] color_q;

    logic [7:0] x_cnt;
    logic [7:0] y_cnt;
    logic       last_sent;

    logic [7:0] cx0;
    logic [7:0] cy0;
    logic [7:0] cx1;
    logic [7:0] cy1;
    logic [7:0] xmin;
    logic [7:0] xmax;
    logic [7:0] ymin;
    logic [7:0] ymax;
    logic       accept;

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign accept    = CMD_VALID && CMD_READY;

    // Clamp the captured corners to the framebuffer and derive the ordered
    // fill bounds; operands only change on acceptance, so these are stable
    // for the whole command.
    always_comb begin
        cx0  = (x0_q > FB_MAX_X) ? FB_MAX_X : x0_q;
        cy0  = (y0_q > FB_MAX_Y) ? FB_MAX_Y : y0_q;
        cx1  = (x1_q > FB_MAX_X) ? FB_MAX_X : x1_q;
        cy1  = (y1_q > FB_MAX_Y) ? FB_MAX_Y : y1_q;
        xmin = 8'd0;
        xmax = FB_MAX_X;
        ymin = 8'd0;
        ymax = FB_MAX_Y;
        case (op_q)
            OP_PIXEL: begin
                xmin = cx0;
                xmax = cx0;
                ymin = cy0;
                ymax = cy0;
            end
            OP_RECT: begin
                xmin = (cx0 < cx1) ? cx0 : cx1;
                xmax = (cx0 < cx1) ? cx1 : cx0;
                ymin = (cy0 < cy1) ? cy0 : cy1;
                ymax = (cy0 < cy1) ? cy1 : cy0;
            end
            default: begin
                xmin = 8'd0;
                xmax = FB_MAX_X;
                ymin = 8'd0;
                ymax = FB_MAX_Y;
            end
        endcase
    end

    // Next-state logic; a no-op command is accepted but never leaves IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (CMD_OP != OP_NOP)) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ABORT ? IDLE : FILL;
            end
            FILL: begin
                if (ABORT || last_sent) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PIXEL_CLOCK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, raster counters and registered framebuffer outputs;
    // the cycle after the final write is spent in FILL to raise DONE.
    always_ff @(posedge PIXEL_CLOCK) begin
        if (RESET) begin
            op_q      <= 2'd0;
            x0_q      <= 8'd0;
            y0_q      <= 8'd0;
            x1_q      <= 8'd0;
            y1_q      <= 8'd0;
            color_q   <= 3'd0;
            x_cnt     <= 8'd0;
            y_cnt     <= 8'd0;
            last_sent <= 1'b0;
            FB_X      <= 8'd0;
            FB_Y      <= 8'd0;
            FB_COLOR  <= 3'd0;
            FB_WRITE  <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            FB_WRITE <= 1'b0;
            DONE     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= CMD_OP;
                        x0_q    <= CMD_X0;
                        y0_q    <= CMD_Y0;
                        x1_q    <= CMD_X1;
                        y1_q    <= CMD_Y1;
                        color_q <= CMD_COLOR;
                        if (CMD_OP == OP_NOP) begin
                            DONE <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (!ABORT) begin
                        x_cnt     <= xmin;
                        y_cnt     <= ymin;
                        last_sent <= 1'b0;
                    end
                end
                FILL: begin
                    if (!ABORT) begin
                        if (last_sent) begin
                            DONE <= 1'b1;
                        end else begin
                            FB_X     <= x_cnt;
                            FB_Y     <= y_cnt;
                            FB_COLOR <= color_q;
                            FB_WRITE <= 1'b1;
                            if (x_cnt == xmax) begin
                                x_cnt <= xmin;
                                if (y_cnt == ymax) begin
                                    last_sent <= 1'b1;
                                end else begin
                                    y_cnt <= y_cnt + 8'd1;
                                end
                            end else begin
                                x_cnt <= x_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    last_sent <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_fill_engine.sv
// tb_gpu_fill_engine: directed test of gpu_fill_engine with hand-computed
// expectations checked by immediate assertions.
module tb_gpu_fill_engine;

    logic       PIXEL_CLOCK;
    logic       RESET;
    logic [1:0] CMD_OP;
    logic [7:0] CMD_X0;
    logic [7:0] CMD_Y0;
    logic [7:0] CMD_X1;
    logic [7:0] CMD_Y1;
    logic [2:0] CMD_COLOR;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       ABORT;
    logic [7:0] FB_X;
    logic [7:0] FB_Y;
    logic [2:0] FB_COLOR;
    logic       FB_WRITE;
    logic       BUSY;
    logic       DONE;

    int n_checks;
    int n_fail;

    gpu_fill_engine dut (
        .PIXEL_CLOCK (PIXEL_CLOCK),
        .RESET       (RESET),
        .CMD_OP      (CMD_OP),
        .CMD_X0      (CMD_X0),
        .CMD_Y0      (CMD_Y0),
        .CMD_X1      (CMD_X1),
        .CMD_Y1      (CMD_Y1),
        .CMD_COLOR   (CMD_COLOR),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .ABORT       (ABORT),
        .FB_X        (FB_X),
        .FB_Y        (FB_Y),
        .FB_COLOR    (FB_COLOR),
        .FB_WRITE    (FB_WRITE),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    // Free-running pixel clock.
    initial begin
        PIXEL_CLOCK = 1'b0;
        forever #5 PIXEL_CLOCK = ~PIXEL_CLOCK;
    end

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge PIXEL_CLOCK);
        #1;
    endtask

    task automatic check_output(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] y0,
                                  input logic [7:0] x1, input logic [7:0] y1, input logic [2:0] color);
        CMD_OP    = op;
        CMD_X0    = x0;
        CMD_Y0    = y0;
        CMD_X1    = x1;
        CMD_Y1    = y1;
        CMD_COLOR = color;
        CMD_VALID = 1'b1;
    endtask

    // Called right after the acceptance edge; walks SETUP, every expected
    // raster write with no gaps, and the DONE cycle.
    task automatic expect_rect(input string tag, input int xmin, input int xmax,
                               input int ymin, input int ymax, input int color);
        int bad;
        int writes;
        bad    = 0;
        writes = 0;
        tick();
        check_output({tag, "_setup_nowrite"}, int'(FB_WRITE), 0);
        check_output({tag, "_setup_busy"}, int'(BUSY), 1);
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                tick();
                if (FB_WRITE === 1'b1) writes++;
                if (FB_WRITE !== 1'b1 || int'(FB_X) != x || int'(FB_Y) != y || int'(FB_COLOR) != color) begin
                    if (bad == 0) $display("[TB] %s first bad pixel: got (%0d,%0d,%0d,w=%0b) want (%0d,%0d,%0d)",
                                           tag, FB_X, FB_Y, FB_COLOR, FB_WRITE, x, y, color);
                    bad++;
                end
            end
        end
        check_output({tag, "_write_count"}, writes, (xmax - xmin + 1) * (ymax - ymin + 1));
        check_output({tag, "_order_errors"}, bad, 0);
        tick();
        check_output({tag, "_end_nowrite"}, int'(FB_WRITE), 0);
        check_output({tag, "_end_done"}, int'(DONE), 1);
        check_output({tag, "_end_ready"}, int'(CMD_READY), 1);
        check_output({tag, "_end_busy"}, int'(BUSY), 0);
    endtask

    // Directed test sequence.
    initial begin
        int extra;
        n_checks  = 0;
        n_fail    = 0;
        RESET     = 1'b1;
        ABORT     = 1'b0;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'd0;
        CMD_X0    = 8'd0;
        CMD_Y0    = 8'd0;
        CMD_X1    = 8'd0;
        CMD_Y1    = 8'd0;
        CMD_COLOR = 3'd0;

        $display("[TB] reset then idle");
        tick();
        tick();
        check_output("rst_ready", int'(CMD_READY), 1);
        check_output("rst_busy", int'(BUSY), 0);
        check_output("rst_done", int'(DONE), 0);
        check_output("rst_write", int'(FB_WRITE), 0);
        check_output("rst_fbx", int'(FB_X), 0);
        check_output("rst_fby", int'(FB_Y), 0);
        check_output("rst_fbcolor", int'(FB_COLOR), 0);
        RESET = 1'b0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (FB_WRITE !== 1'b0 || DONE !== 1'b0) extra++;
        end
        check_output("idle_quiet", extra, 0);

        $display("[TB] single pixel");
        apply_stimulus(2'b00, 8'd10, 8'd20, 8'd0, 8'd0, 3'd5);
        tick();
        CMD_VALID = 1'b0;
        CMD_X0    = 8'd99;
        CMD_COLOR = 3'd1;
        check_output("pix_accept_busy", int'(BUSY), 1);
        check_output("pix_accept_ready", int'(CMD_READY), 0);
        expect_rect("pix", 10, 10, 20, 20, 5);
        tick();
        check_output("pix_done_pulse_one", int'(DONE), 0);
        check_output("pix_hold_x", int'(FB_X), 10);
        check_output("pix_hold_y", int'(FB_Y), 20);
        check_output("pix_hold_color", int'(FB_COLOR), 5);

        $display("[TB] reserved opcode");
        apply_stimulus(2'b11, 8'd1, 8'd1, 8'd1, 8'd1, 3'd3);
        tick();
        CMD_VALID = 1'b0;
        check_output("nop_done", int'(DONE), 1);
        check_output("nop_ready", int'(CMD_READY), 1);
        check_output("nop_busy", int'(BUSY), 0);
        check_output("nop_write", int'(FB_WRITE), 0);
        tick();
        check_output("nop_done_clear", int'(DONE), 0);

        $display("[TB] swapped clipped rectangle");
        apply_stimulus(2'b01, 8'd3, 8'd2, 8'd1, 8'd250, 3'd2);
        tick();
        CMD_VALID = 1'b0;
        expect_rect("rect", 1, 3, 2, 149, 2);

        $display("[TB] clear screen");
        apply_stimulus(2'b10, 8'd50, 8'd60, 8'd70, 8'd80, 3'd7);
        tick();
        CMD_VALID = 1'b0;
        expect_rect("clear", 0, 199, 0, 149, 7);

        $display("[TB] abort clear after 50 writes");
        apply_stimulus(2'b10, 8'd0, 8'd0, 8'd0, 8'd0, 3'd7);
        tick();
        CMD_VALID = 1'b0;
        tick();
        extra = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (FB_WRITE !== 1'b1 || int'(FB_X) != i) extra++;
        end
        check_output("abort_pre_writes_bad", extra, 0);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check_output("abort_write", int'(FB_WRITE), 0);
        check_output("abort_done", int'(DONE), 0);
        check_output("abort_ready", int'(CMD_READY), 1);
        check_output("abort_busy", int'(BUSY), 0);
        check_output("abort_hold_x", int'(FB_X), 49);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (FB_WRITE !== 1'b0 || DONE !== 1'b0) extra++;
        end
        check_output("abort_quiet_after", extra, 0);
        apply_stimulus(2'b00, 8'd5, 8'd6, 8'd0, 8'd0, 3'd3);
        tick();
        CMD_VALID = 1'b0;
        expect_rect("post_abort_pix", 5, 5, 6, 6, 3);

        $display("[TB] back-to-back pixels");
        apply_stimulus(2'b00, 8'd1, 8'd1, 8'd0, 8'd0, 3'd1);
        tick();
        apply_stimulus(2'b00, 8'd2, 8'd3, 8'd0, 8'd0, 3'd4);
        expect_rect("b2b_first", 1, 1, 1, 1, 1);
        tick();
        CMD_VALID = 1'b0;
        check_output("b2b_second_accept_busy", int'(BUSY), 1);
        check_output("b2b_second_accept_done", int'(DONE), 0);
        expect_rect("b2b_second", 2, 2, 3, 3, 4);

        $display("[TB] reset mid-rectangle");
        apply_stimulus(2'b01, 8'd0, 8'd0, 8'd9, 8'd9, 3'd6);
        tick();
        CMD_VALID = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check_output("mid_pre_x", int'(FB_X), 4);
        check_output("mid_pre_y", int'(FB_Y), 1);
        RESET = 1'b1;
        ABORT = 1'b1;
        tick();
        RESET = 1'b0;
        ABORT = 1'b0;
        check_output("mid_rst_write", int'(FB_WRITE), 0);
        check_output("mid_rst_x", int'(FB_X), 0);
        check_output("mid_rst_y", int'(FB_Y), 0);
        check_output("mid_rst_color", int'(FB_COLOR), 0);
        check_output("mid_rst_done", int'(DONE), 0);
        check_output("mid_rst_ready", int'(CMD_READY), 1);
        check_output("mid_rst_busy", int'(BUSY), 0);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (FB_WRITE !== 1'b0 || DONE !== 1'b0) extra++;
        end
        check_output("mid_rst_quiet", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_fill_engine.md
Name: gpu_fill_engine

Overview:
- Command-driven pixel generator sitting directly upstream of the framebuffer write port.
- Takes one decoded draw command (single pixel, rectangle fill or full-screen clear), clips and orders its corners, then emits one framebuffer write per PIXEL_CLOCK in raster order.
- Replaces the CPU's per-pixel register writes for bulk fills. Its outputs drive the framebuffer's x/y/colour/write inputs directly.

Parameters:
- FB_MAX_X, 199, largest legal framebuffer column (8-bit coordinate space).
- FB_MAX_Y, 149, largest legal framebuffer row.

Ports:
- PIXEL_CLOCK  in  1  sole clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- CMD_OP  in  2  00 = pixel at (X0,Y0), 01 = rectangle fill, 10 = clear screen, 11 = reserved/no-op.
- CMD_X0, CMD_Y0, CMD_X1, CMD_Y1  in  8 each  corner coordinates.
- CMD_COLOR  in  3  RGB fill colour.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  engine can accept a command.
- ABORT  in  1  cancel the active command.
- FB_X  out  8  framebuffer column.
- FB_Y  out  8  framebuffer row.
- FB_COLOR  out  3  framebuffer colour.
- FB_WRITE  out  1  one-cycle write strobe per pixel.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset values, applied at the first posedge with RESET=1 and overriding everything else, including mid-command:
  - state IDLE
  - CMD_READY=1
  - BUSY=0
  - DONE=0
  - FB_WRITE=0
  - FB_X=0, FB_Y=0, FB_COLOR=0
- States and transitions:
  - IDLE → SETUP → FILL → IDLE.
  - CMD_READY=1 only in IDLE. BUSY=1 in SETUP and FILL.
- Acceptance:
  - A command is accepted on a posedge where CMD_VALID & CMD_READY; call that edge N.
  - Operands are captured on edge N. Later input changes are ignored until the engine returns to IDLE.
  - OP=11 is accepted but goes directly back to IDLE: DONE=1 after edge N, no writes.
- SETUP (one cycle):
  - Each coordinate is clamped to FB_MAX_X / FB_MAX_Y.
  - For OP=01, corners are swapped so that xmin≤xmax and ymin≤ymax.
  - OP=00 sets xmin=xmax=X0 and ymin=ymax=Y0.
  - OP=10 sets the rectangle to (0,0)-(FB_MAX_X,FB_MAX_Y); X/Y inputs are ignored.
- FILL:
  - The first FB_WRITE is visible after edge N+2.
  - One write per cycle, with no gaps: x runs xmin..xmax inner, y runs ymin..ymax outer, both ascending.
  - FB_X, FB_Y and FB_COLOR are valid whenever FB_WRITE=1.
  - Total writes = (xmax-xmin+1)*(ymax-ymin+1). The last write is on the edge where x==xmax && y==ymax.
- Completion:
  - The cycle after the last write has FB_WRITE=0, DONE=1, CMD_READY=1 and BUSY=0.
  - A new command may be accepted on that same edge, so back-to-back commands lose no cycles beyond SETUP.
- Abort:
  - ABORT=1 during SETUP or FILL returns to IDLE on that edge. The next cycle has FB_WRITE=0 and DONE=0 (aborts never signal DONE).
  - ABORT is ignored in IDLE.
  - If ABORT and RESET are both high, RESET wins (identical outcome).
- Counters:
  - x and y counters are 8-bit. There is no wrap, because the clamp guarantees max ≤ FB_MAX_*.
- Simultaneity: CMD_VALID while BUSY is held off (CMD_READY=0) and is not lost; the issuer keeps it asserted.
- FB_X/FB_Y/FB_COLOR hold their last values when FB_WRITE=0.

Test Plan:
- Reset then idle: RESET high for 2 cycles → CMD_READY=1, BUSY=0, FB_WRITE never asserts.
- Single pixel: OP=00, X0=10, Y0=20, COLOR=5 accepted at N → exactly one write (10,20,5) after N+2; DONE pulse after N+3; CMD_READY=1 again.
- Swapped, clipped rectangle: OP=01, X0=3, Y0=2, X1=1, Y1=250, COLOR=2 → 3×148=444 writes in order (1,2),(2,2),(3,2),(1,3)…(3,149); no gaps; then one DONE.
- Clear screen: OP=10, COLOR=7 → 30000 consecutive writes; first write (0,0), last write (199,149); DONE one cycle later.
- Abort: start OP=10 and raise ABORT after the 50th write → no further writes; DONE stays 0; CMD_READY=1 on the next cycle; a following OP=00 executes normally.
- Back-to-back and reset mid-fill: hold CMD_VALID with two queued pixel commands → the second is accepted on the DONE cycle. Separately, assert RESET mid-rectangle → all outputs are at their reset values after that edge.
